muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer for the shared multi-cycle multiply and divide units used by the EX stage. It accepts one HI/LO-class operation per EX instruction and latches the operands. It drives the `mul` and `div` unit handshakes, raises `stallreq` until the result exists, and issues a single HI/LO write when the pipeline advances. It replaces the ad-hoc combinational divide sequencing inside EX with a registered FSM that also covers flush and multiplier latency.

## Interface
Parameters:
- `MUL_LAT`, default 2: cycles from operand presentation to a valid `mul_result`; legal range 1–15.

Ports:
- `clk` in 1: clock, rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `op` in 6: one-hot `{mult, multu, div, divu, mthi, mtlo}` from the ID/EX register.
  - All zero means no operation.
  - If several bits are set, priority is left to right.
- `src1` in 32: rs value, forwarded.
- `src2` in 32: rt value, forwarded.
- `stall_down` in 1: `stall[3]`; EX output held this cycle.
- `flush` in 1: kill the in-flight op.
- `stallreq` out 1: hold EX and earlier stages.
- `mul_signed` out 1: to `mul`.
- `mul_ina` out 32: to `mul`.
- `mul_inb` out 32: to `mul`.
- `mul_result` in 64: from `mul`.
- `div_signed` out 1: to `div`.
- `div_opdata1` out 32: to `div`.
- `div_opdata2` out 32: to `div`.
- `div_start` out 1: to `div`.
- `div_annul` out 1: to `div`.
- `div_ready` in 1: from `div`.
- `div_result` in 64: from `div`, as `{remainder, quotient}`.
- `hi_we` out 1: HI write enable.
- `lo_we` out 1: LO write enable.
- `hi_wdata` out 32: HI write data.
- `lo_wdata` out 32: LO write data.

## Operation
- States:
  - `IDLE`: no operation in progress.
  - `MUL_WAIT`: waiting for `mul_result`.
  - `DIV_RUN`: waiting for `div_ready`.
  - `DONE`: result held, waiting to write.
- `IDLE` transitions:
  - `mult`/`multu`: latch `src1`/`src2` into the operand registers and set the signed flag. Load the counter with `MUL_LAT-1`, then go to `MUL_WAIT`.
  - `div`/`divu`: latch the operands and the signed flag, then go to `DIV_RUN`.
  - `mthi`/`mtlo`: no state change. `hi_we`/`lo_we` = 1 combinationally, with `src1` on the matching wdata.
- `MUL_WAIT`:
  - Counter decrements each cycle.
  - When the counter reaches 0, capture `mul_result` into the result register and go to `DONE`.
- `DIV_RUN`:
  - `div_start` = 1 and operands are held stable every cycle.
  - When `div_ready` = 1, capture `div_result` and go to `DONE`. `div_start` is 0 in the ready cycle.
- `DONE`:
  - If `stall_down` = 0: `hi_we` = `lo_we` = 1 with `hi_wdata` = result[63:32] and `lo_wdata` = result[31:0]; next state is `IDLE`.
  - If `stall_down` = 1: stay in `DONE` with no write.
- `stallreq` = (`IDLE` and a mul/div bit set in `op`) or state ∈ {`MUL_WAIT`, `DIV_RUN`}. It is 0 in `DONE` so the instruction leaves EX.
- The instruction held in EX during `DONE` is not re-accepted. Acceptance occurs only from `IDLE`, which is reached only after the write.
- `flush` in `MUL_WAIT`, `DIV_RUN` or `DONE`:
  - Next state is `IDLE`, with no HI/LO write.
  - `div_annul` = 1 for that cycle if the state was `DIV_RUN`.
- `flush` in `IDLE` suppresses acceptance and the `mthi`/`mtlo` write.
- Widths: operands are passed unchanged; signedness is carried only on `mul_signed`/`div_signed`.
- Reset (asynchronous): state `IDLE`, counter 0, operand and result registers 0.
- Reset values of all outputs: 0.

## Timing
- mult/multu: instruction enters EX at cycle 0; the HI/LO write occurs at cycle `MUL_LAT`+1 when `stall_down` = 0. `stallreq` is high for cycles 0..`MUL_LAT`.
- div/divu: the write occurs one cycle after `div_ready` is seen (`DONE` cycle).
- mthi/mtlo: write in the same cycle, zero stall.
- `div_ready` arriving together with `flush`: flush wins; no capture, `div_annul` = 1.
- Outputs to `mul`/`div` are registered. `stallreq`, `hi_we` and `lo_we` are combinational from state and inputs.
- Back-to-back mul/div: the second op is accepted in the cycle after `DONE`, with no bubble beyond that.

## Configuration
- `MULDIV_DIVZERO_CHK_EN`:
  - Defined: div/divu with `src2` = 0 bypasses the divider and goes directly `IDLE`→`DONE`. Result is hi = `src1`, lo = 32'hFFFFFFFF; `div_start` is never asserted; `stallreq` is high for 1 cycle.
  - Undefined: a divide by zero runs through the divider like any other divide, and the result is whatever `div` returns.

## Test plan
- mult, `src1` = 32'hFFFFFFFF, `src2` = 2, `MUL_LAT` = 2 → `stallreq` high 3 cycles; then hi = 32'hFFFFFFFF, lo = 32'hFFFFFFFE, with a single `hi_we`/`lo_we` pulse.
- multu with the same operands → hi = 32'h00000001, lo = 32'hFFFFFFFE.
- div −7/2, with `div` model ready after 33 cycles → `div_start` high 33 cycles; then lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF.
- divu 100/7 with `stall_down` high 3 cycles during `DONE` → no write until `stall_down` falls; then exactly one write of lo = 14, hi = 2.
- Flush at cycle 10 of a div → `div_annul` pulse, return to `IDLE`, no HI/LO write. A subsequent mthi `src1` = 32'h12345678 writes HI in the same cycle with `stallreq` = 0.
- With `MULDIV_DIVZERO_CHK_EN`, div 5/0 → `div_start` never asserted; then hi = 5, lo = 32'hFFFFFFFF. Assert `resetn` = 0 mid-div in a separate run → all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the EX stage: latches operands, drives the shared mul/div units,
// stalls the pipeline until the result exists and issues one HI/LO write. Optional macro: MULDIV_DIVZERO_CHK_EN.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        stall_down,
    input  logic        flush,
    output logic        stallreq,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_start,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [63:0] r_result;
    logic        r_mul_signed;
    logic [31:0] r_mul_ina;
    logic [31:0] r_mul_inb;
    logic        r_div_signed;
    logic [31:0] r_div_opdata1;
    logic [31:0] r_div_opdata2;
    logic        r_div_start;

    logic        w_op_mul;
    logic        w_op_div;
    logic        w_op_mthi;
    logic        w_op_mtlo;
    logic        w_div_zero;
    logic        w_stallreq;
    logic        w_hi_we;
    logic        w_lo_we;
    logic [31:0] w_hi_wdata;
    logic [31:0] w_lo_wdata;
    logic        w_div_annul;
    logic        w_accept_mul;
    logic        w_accept_div;
    logic        w_accept_dz;
    logic        w_cap_mul;
    logic        w_cap_div;

    // Priority decode: leftmost set bit of {mult, multu, div, divu, mthi, mtlo} wins.
    assign w_op_mul  = op[5] | op[4];
    assign w_op_div  = ~w_op_mul & (op[3] | op[2]);
    assign w_op_mthi = (op[5:2] == 4'd0) & op[1];
    assign w_op_mtlo = (op[5:1] == 5'd0) & op[0];

`ifdef MULDIV_DIVZERO_CHK_EN
    assign w_div_zero = (src2 == 32'd0);
`else
    assign w_div_zero = 1'b0;
`endif

    // Next-state, stall and HI/LO write decode.
    always_comb begin
        w_next       = r_state;
        w_stallreq   = 1'b0;
        w_hi_we      = 1'b0;
        w_lo_we      = 1'b0;
        w_hi_wdata   = 32'd0;
        w_lo_wdata   = 32'd0;
        w_div_annul  = 1'b0;
        w_accept_mul = 1'b0;
        w_accept_div = 1'b0;
        w_accept_dz  = 1'b0;
        w_cap_mul    = 1'b0;
        w_cap_div    = 1'b0;
        case (r_state)
            IDLE: begin
                w_stallreq = w_op_mul | w_op_div;
                if (flush) begin
                    w_next = IDLE;
                end else if (w_op_mul) begin
                    w_accept_mul = 1'b1;
                    w_next       = MUL_WAIT;
                end else if (w_op_div) begin
                    if (w_div_zero) begin
                        w_accept_dz = 1'b1;
                        w_next      = DONE;
                    end else begin
                        w_accept_div = 1'b1;
                        w_next       = DIV_RUN;
                    end
                end else if (w_op_mthi) begin
                    w_hi_we    = 1'b1;
                    w_hi_wdata = src1;
                end else if (w_op_mtlo) begin
                    w_lo_we    = 1'b1;
                    w_lo_wdata = src1;
                end else begin
                    w_next = IDLE;
                end
            end
            MUL_WAIT: begin
                w_stallreq = 1'b1;
                if (flush) begin
                    w_next = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_cap_mul = 1'b1;
                    w_next    = DONE;
                end else begin
                    w_next = MUL_WAIT;
                end
            end
            DIV_RUN: begin
                w_stallreq = 1'b1;
                if (flush) begin
                    // A ready arriving with flush is dropped; the divider is told to abandon.
                    w_div_annul = 1'b1;
                    w_next      = IDLE;
                end else if (div_ready) begin
                    w_cap_div = 1'b1;
                    w_next    = DONE;
                end else begin
                    w_next = DIV_RUN;
                end
            end
            DONE: begin
                if (flush) begin
                    w_next = IDLE;
                end else if (!stall_down) begin
                    w_hi_we    = 1'b1;
                    w_lo_we    = 1'b1;
                    w_hi_wdata = r_result[63:32];
                    w_lo_wdata = r_result[31:0];
                    w_next     = IDLE;
                end else begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Multiplier latency counter and operand registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= 4'd0;
            r_mul_signed <= 1'b0;
            r_mul_ina    <= 32'd0;
            r_mul_inb    <= 32'd0;
        end else if (w_accept_mul) begin
            r_cnt        <= LAT_M1;
            r_mul_signed <= op[5];
            r_mul_ina    <= src1;
            r_mul_inb    <= src2;
        end else if ((r_state == MUL_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Divider operand registers and start request, held for the whole run.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div_signed  <= 1'b0;
            r_div_opdata1 <= 32'd0;
            r_div_opdata2 <= 32'd0;
            r_div_start   <= 1'b0;
        end else if (w_accept_div) begin
            r_div_signed  <= op[3];
            r_div_opdata1 <= src1;
            r_div_opdata2 <= src2;
            r_div_start   <= 1'b1;
        end else if ((r_state == DIV_RUN) && (flush || div_ready)) begin
            r_div_start <= 1'b0;
        end else begin
            r_div_start <= r_div_start;
        end
    end

    // Result register: {hi, lo}; the divider already returns {remainder, quotient}.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_result <= 64'd0;
        end else if (w_cap_mul) begin
            r_result <= mul_result;
        end else if (w_cap_div) begin
            r_result <= div_result;
        end else if (w_accept_dz) begin
            r_result <= {src1, 32'hFFFF_FFFF};
        end else begin
            r_result <= r_result;
        end
    end

    assign stallreq    = w_stallreq;
    assign mul_signed  = r_mul_signed;
    assign mul_ina     = r_mul_ina;
    assign mul_inb     = r_mul_inb;
    assign div_signed  = r_div_signed;
    assign div_opdata1 = r_div_opdata1;
    assign div_opdata2 = r_div_opdata2;
    // Start drops in the ready cycle so the divider does not relaunch.
    assign div_start   = r_div_start & ~div_ready;
    assign div_annul   = w_div_annul;
    assign hi_we       = w_hi_we;
    assign lo_we       = w_lo_we;
    assign hi_wdata    = w_hi_wdata;
    assign lo_wdata    = w_lo_wdata;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with behavioural mul (1-stage) and div (33-cycle) models.
module tb_muldiv_ctrl;

    localparam logic [5:0] OP_MULT  = 6'b100000;
    localparam logic [5:0] OP_MULTU = 6'b010000;
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000010;
    localparam logic [5:0] OP_MTLO  = 6'b000001;

    logic        clk;
    logic        resetn;
    logic [5:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        stall_down;
    logic        flush;
    logic        stallreq;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_start;
    logic        div_annul;
    logic        div_ready;
    logic [63:0] div_result;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int nchecks = 0;
    int nerr    = 0;
    int hi_pulses = 0;
    int lo_pulses = 0;
    int hb;
    int lb;
    int n;
    bit seen;
    logic [5:0] dcnt;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk(clk), .resetn(resetn), .op(op), .src1(src1), .src2(src2),
        .stall_down(stall_down), .flush(flush), .stallreq(stallreq),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
        .div_signed(div_signed), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_start(div_start), .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: one register stage after the registered operands.
    always @(posedge clk) begin
        if (mul_signed)
            mul_result <= {{32{mul_ina[31]}}, mul_ina} * {{32{mul_inb[31]}}, mul_inb};
        else
            mul_result <= {32'd0, mul_ina} * {32'd0, mul_inb};
    end

    // Divider model: ready once start has been held for 33 cycles.
    always @(posedge clk or negedge resetn) begin
        if (!resetn)        dcnt <= 6'd0;
        else if (div_start) dcnt <= dcnt + 6'd1;
        else                dcnt <= 6'd0;
    end
    assign div_ready = (dcnt == 6'd33);

    always_comb begin
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = div_opdata1;
        sb = div_opdata2;
        if (div_opdata2 == 32'd0)
            div_result = 64'd0;
        else if (div_signed)
            div_result = {32'(sa % sb), 32'(sa / sb)};
        else
            div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
    end

    always @(negedge clk) begin
        if (hi_we) hi_pulses++;
        if (lo_we) lo_pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(output int cnt, output bit got);
        cnt = 0;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (div_ready) begin
                got = 1'b1;
                break;
            end
            if (div_start) cnt++;
        end
    endtask

    initial begin
        resetn = 1'b0; op = 6'd0; src1 = 32'd0; src2 = 32'd0; stall_down = 1'b0; flush = 1'b0;
        #12;
        chk("rst_ctrl", {58'd0, stallreq, div_start, div_annul, hi_we, lo_we, mul_signed}, 64'd0);
        chk("rst_data", {63'd0, |{mul_ina, mul_inb, div_opdata1, div_opdata2, hi_wdata, lo_wdata, div_signed}}, 64'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // mult -1 * 2
        tick(); op = OP_MULT; src1 = 32'hFFFF_FFFF; src2 = 32'd2; hb = hi_pulses; lb = lo_pulses; #1;
        chk("mult_c0_stall", {63'd0, stallreq}, 64'd1);
        chk("mult_c0_nowe", {62'd0, hi_we, lo_we}, 64'd0);
        tick(); #1;
        chk("mult_c1_stall", {63'd0, stallreq}, 64'd1);
        chk("mult_ops", {31'd0, mul_signed, mul_ina}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        chk("mult_inb", {32'd0, mul_inb}, 64'd2);
        tick(); #1;
        chk("mult_c2_stall", {63'd0, stallreq}, 64'd1);
        tick(); #1;
        chk("mult_done_stall", {63'd0, stallreq}, 64'd0);
        chk("mult_we", {62'd0, hi_we, lo_we}, 64'd3);
        chk("mult_data", {hi_wdata, lo_wdata}, 64'hFFFF_FFFF_FFFF_FFFE);

        // multu accepted immediately after DONE
        tick(); op = OP_MULTU; #1;
        chk("mult_hi_pulses", 64'(hi_pulses - hb), 64'd1);
        chk("mult_lo_pulses", 64'(lo_pulses - lb), 64'd1);
        chk("multu_b2b_stall", {63'd0, stallreq}, 64'd1);
        chk("multu_c0_nowe", {63'd0, hi_we}, 64'd0);
        tick(); #1;
        chk("multu_unsigned", {63'd0, mul_signed}, 64'd0);
        tick(); tick(); #1;
        chk("multu_we", {62'd0, hi_we, lo_we}, 64'd3);
        chk("multu_data", {hi_wdata, lo_wdata}, 64'h0000_0001_FFFF_FFFE);
        tick(); op = 6'd0; #1;
        chk("idle_stall", {63'd0, stallreq}, 64'd0);

        // div -7 / 2
        tick(); op = OP_DIV; src1 = 32'hFFFF_FFF9; src2 = 32'd2; #1;
        chk("div_c0_stall", {63'd0, stallreq}, 64'd1);
        chk("div_c0_nostart", {63'd0, div_start}, 64'd0);
        run_div(n, seen);
        chk("div_ready_seen", {63'd0, seen}, 64'd1);
        chk("div_start_cycles", 64'(n), 64'd33);
        chk("div_ready_start", {63'd0, div_start}, 64'd0);
        chk("div_ready_stall", {63'd0, stallreq}, 64'd1);
        chk("div_ops", {31'd0, div_signed, div_opdata1}, {31'd0, 1'b1, 32'hFFFF_FFF9});
        tick(); #1;
        chk("div_done_stall", {63'd0, stallreq}, 64'd0);
        chk("div_we", {62'd0, hi_we, lo_we}, 64'd3);
        chk("div_data", {hi_wdata, lo_wdata}, 64'hFFFF_FFFF_FFFF_FFFD);
        tick(); op = 6'd0;

        // divu 100 / 7 with stall_down held in DONE
        tick(); op = OP_DIVU; src1 = 32'd100; src2 = 32'd7; hb = hi_pulses; lb = lo_pulses;
        run_div(n, seen);
        chk("divu_ready_seen", {63'd0, seen}, 64'd1);
        tick(); stall_down = 1'b1; #1;
        chk("divu_stall1_nowe", {62'd0, hi_we, lo_we}, 64'd0);
        chk("divu_done_nostall", {63'd0, stallreq}, 64'd0);
        tick(); #1;
        chk("divu_stall2_nowe", {62'd0, hi_we, lo_we}, 64'd0);
        tick(); #1;
        chk("divu_stall3_nowe", {62'd0, hi_we, lo_we}, 64'd0);
        tick(); stall_down = 1'b0; #1;
        chk("divu_we", {62'd0, hi_we, lo_we}, 64'd3);
        chk("divu_data", {hi_wdata, lo_wdata}, {32'd2, 32'd14});
        tick(); op = 6'd0; #1;
        chk("divu_after_nowe", {62'd0, hi_we, lo_we}, 64'd0);
        chk("divu_hi_pulses", 64'(hi_pulses - hb), 64'd1);
        chk("divu_lo_pulses", 64'(lo_pulses - lb), 64'd1);

        // flush in cycle 10 of a divide, then mthi/mtlo
        tick(); op = OP_DIV; src1 = 32'd20; src2 = 32'd3; hb = hi_pulses; lb = lo_pulses;
        repeat (9) tick();
        tick(); flush = 1'b1; #1;
        chk("flush_annul", {63'd0, div_annul}, 64'd1);
        chk("flush_nowe", {62'd0, hi_we, lo_we}, 64'd0);
        tick(); flush = 1'b0; op = OP_MTHI; src1 = 32'h1234_5678; #1;
        chk("mthi_stall", {63'd0, stallreq}, 64'd0);
        chk("mthi_we", {62'd0, hi_we, lo_we}, 64'd2);
        chk("mthi_data", {32'd0, hi_wdata}, 64'h1234_5678);
        chk("post_flush_quiet", {62'd0, div_annul, div_start}, 64'd0);
        tick(); op = OP_MTLO; src1 = 32'hCAFE_F00D; #1;
        chk("mtlo_we", {62'd0, hi_we, lo_we}, 64'd1);
        chk("mtlo_data", {32'd0, lo_wdata}, 64'hCAFE_F00D);
        tick(); op = OP_MTHI; flush = 1'b1; #1;
        chk("mthi_flush_idle", {62'd0, hi_we, lo_we}, 64'd0);
        tick(); flush = 1'b0; op = 6'd0; #1;
        chk("flush_hi_pulses", 64'(hi_pulses - hb), 64'd1);
        chk("flush_lo_pulses", 64'(lo_pulses - lb), 64'd1);

        // divide by zero
`ifdef MULDIV_DIVZERO_CHK_EN
        tick(); op = OP_DIV; src1 = 32'd5; src2 = 32'd0; #1;
        chk("dz_c0_stall", {63'd0, stallreq}, 64'd1);
        tick(); #1;
        chk("dz_done_stall", {63'd0, stallreq}, 64'd0);
        chk("dz_nostart", {63'd0, div_start}, 64'd0);
        chk("dz_we", {62'd0, hi_we, lo_we}, 64'd3);
        chk("dz_data", {hi_wdata, lo_wdata}, {32'd5, 32'hFFFF_FFFF});
        tick(); op = 6'd0;
`else
        tick(); op = OP_DIV; src1 = 32'd5; src2 = 32'd0; #1;
        tick(); #1;
        chk("dz_runs_divider", {63'd0, div_start}, 64'd1);
        tick(); flush = 1'b1;
        tick(); flush = 1'b0; op = 6'd0;
`endif

        // asynchronous reset in the middle of a divide
        tick(); op = OP_DIVU; src1 = 32'd50; src2 = 32'd5;
        tick(); tick(); tick(); #1;
        chk("pre_rst_start", {63'd0, div_start}, 64'd1);
        resetn = 1'b0; op = 6'd0; #1;
        chk("midrst_ctrl", {58'd0, stallreq, div_start, div_annul, hi_we, lo_we, mul_signed}, 64'd0);
        chk("midrst_mul", {mul_ina, mul_inb}, 64'd0);
        chk("midrst_div", {div_opdata1, div_opdata2}, 64'd0);
        chk("midrst_misc", {29'd0, div_signed, hi_wdata, 2'd0}, 64'd0);
        #10 resetn = 1'b1;
        tick(); #1;
        chk("post_rst_idle", {62'd0, stallreq, div_start}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
